aes_inv_cipher: RTL

Iterative AES-128 decryption core: accepts one 128-bit ciphertext block over a valid/ready handshake and returns the 128-bit plaintext after 10 inverse rounds, one round per clock. It is the decrypt-side counterpart of the encryption round datapath and uses the same byte-to-state mapping as the encrypt-side row shift. Round keys come from an external key store that is indexed by this block.

---
 rtl/aes_inv_cipher.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys fetched
// from an external key store through rk_idx/rk.

module inv_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    logic [7:0] aff;
    assign aff   = rotl8(in_i, 1) ^ rotl8(in_i, 3) ^ rotl8(in_i, 6) ^ 8'h05;
    assign out_o = gf_inv(aff);
endmodule

module aes_inv_cipher (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic [127:0] st_q, st_d;
    logic [127:0] pt_q, pt_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] isr, isb, ark, imc;

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        int j;
        for (int k = 0; k < 16; k++) begin
            j = (k % 4) + 4 * (((k / 4) - (k % 4) + 4) % 4);
            o[127-8*k -: 8] = s[127-8*j -: 8];
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] x1 [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            x1[i] = a[31-8*i -: 8];
            x2[i] = xtime(x1[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ x1[i];
            mb[i] = x8[i] ^ x2[i] ^ x1[i];
            md[i] = x8[i] ^ x4[i] ^ x1[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    assign isr = inv_shift_rows(st_q);

    for (genvar g = 0; g < 16; g++) begin : g_isb
        inv_sbox u_inv_sbox (
            .in_i  (isr[127-8*g -: 8]),
            .out_o (isb[127-8*g -: 8])
        );
    end

    assign ark = isb ^ rk;
    assign imc = inv_mix_columns(ark);

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        pt_d        = pt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = ct ^ rk;
                    rnd_d   = 4'd9;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d  = imc;
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) state_d = FINAL;
            end
            FINAL: begin
                pt_d        = ark;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // rk_idx is registered from the next state so the key store sees a clean index.
        case (state_d)
            ROUND:   rk_idx_d = rnd_d;
            FINAL:   rk_idx_d = 4'd0;
            default: rk_idx_d = 4'd10;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rnd_q       <= 4'd0;
            rk_idx_q    <= 4'd10;
            st_q        <= '0;
            pt_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            rk_idx_q    <= rk_idx_d;
            st_q        <= st_d;
            pt_q        <= pt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rk_idx    = rk_idx_q;
    assign out_valid = out_valid_q;
    assign pt        = pt_q;
endmodule
